// File: rtl/uart_cmd_dispatch.sv
// uart_cmd_dispatch: frames UART rx bytes between START_CHAR and END_CHAR,
// matches the payload against a table of commands, reports the result with
// single-cycle pulses and streams the matching response out to the UART tx.
module uart_cmd_dispatch #(
    parameter int         CMD_NUM     = 4,
    parameter int         IDX_W       = 2,
    parameter int         CMD_LEN     = 11,
    parameter int         RSP_LEN     = 18,
    parameter logic [7:0] START_CHAR  = 8'h2E,
    parameter logic [7:0] END_CHAR    = 8'h0D,
    parameter int         TIMEOUT_CYC = 1_000_000
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [7:0]                   rx_data,
    input  logic                         rx_valid,
    output logic [7:0]                   tx_data,
    output logic                         tx_start,
    input  logic                         tx_done,
    input  logic [CMD_NUM*CMD_LEN*8-1:0] cmd_table,
    input  logic [CMD_NUM*RSP_LEN*8-1:0] rsp_table,
    output logic                         match_pulse,
    output logic [IDX_W-1:0]             match_idx,
    output logic                         nomatch_pulse,
    output logic                         drop_pulse,
    output logic                         busy
);

    localparam int CNT_W = $clog2(CMD_LEN + 1);
    localparam int PTR_W = $clog2(RSP_LEN + 1);
    localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {R_IDLE, R_RECV, R_CMP}  rx_state_t;
    typedef enum logic [1:0] {T_IDLE, T_LOAD, T_WAIT} tx_state_t;

    // receive side
    rx_state_t          rx_state, rx_next;
    logic [7:0]         frame_buf [CMD_LEN];
    logic [CNT_W-1:0]   count;
    logic               overflow;
    logic [TMR_W-1:0]   idle_tmr;
    logic [CMD_NUM-1:0] entry_hit;
    logic               hit;
    logic [IDX_W-1:0]   hit_idx;

    // transmit side
    tx_state_t          tx_state, tx_next;
    logic [IDX_W-1:0]   tx_idx;
    logic [PTR_W-1:0]   ptr;
    logic               load_end;

    // Byte p of response idx; positions past the table read as terminator.
    function automatic logic [7:0] rsp_byte(input logic [IDX_W-1:0] idx,
                                            input logic [PTR_W-1:0] p);
        logic [7:0] b;
        b = 8'h00;
        if (int'(p) < RSP_LEN)
            b = rsp_table[(int'(idx)*RSP_LEN + RSP_LEN - 1 - int'(p))*8 +: 8];
        return b;
    endfunction

    // Per-entry compare: entry length is bytes before its first zero byte.
    always_comb begin
        entry_hit = '0;
        for (int k = 0; k < CMD_NUM; k++) begin
            logic [7:0] c;
            int         len;
            logic       ended;
            logic       same;
            len   = 0;
            ended = 1'b0;
            same  = 1'b1;
            for (int i = 0; i < CMD_LEN; i++) begin
                c = cmd_table[(k*CMD_LEN + CMD_LEN - 1 - i)*8 +: 8];
                if (!ended) begin
                    if (c == 8'h00) begin
                        ended = 1'b1;
                    end else begin
                        len++;
                        if (frame_buf[i] != c) same = 1'b0;
                    end
                end
            end
            entry_hit[k] = !overflow && (len != 0) && (int'(count) == len) && same;
        end
    end

    // Priority select: the lowest matching index wins.
    always_comb begin
        hit     = |entry_hit;
        hit_idx = '0;
        for (int k = CMD_NUM - 1; k >= 0; k--) begin
            if (entry_hit[k]) hit_idx = IDX_W'(k);
        end
    end

    // Rx next-state logic.
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            R_IDLE: if (rx_valid && rx_data == START_CHAR) rx_next = R_RECV;
            R_RECV: begin
                if (rx_valid) begin
                    if (rx_data == END_CHAR) rx_next = R_CMP;
                end else if (idle_tmr == TMR_W'(TIMEOUT_CYC - 1)) begin
                    rx_next = R_IDLE;
                end
            end
            R_CMP:   rx_next = R_IDLE;
            default: rx_next = R_IDLE;
        endcase
    end

    // Rx state register.
    // NOTE: all sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rx_state <= R_IDLE;
        else      rx_state <= rx_next;
    end

    // Rx datapath: frame buffer, byte count, overflow, idle timer and result pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: the frame buffer is small and deliberately cleared, so reset leaves no stale payload.
            for (int i = 0; i < CMD_LEN; i++) frame_buf[i] <= '0;
            count         <= '0;
            overflow      <= 1'b0;
            idle_tmr      <= '0;
            match_pulse   <= 1'b0;
            match_idx     <= '0;
            nomatch_pulse <= 1'b0;
        end else begin
            match_pulse   <= 1'b0;
            nomatch_pulse <= 1'b0;
            case (rx_state)
                R_IDLE: begin
                    if (rx_valid && rx_data == START_CHAR) begin
                        count    <= '0;
                        overflow <= 1'b0;
                        idle_tmr <= '0;
                    end
                end
                R_RECV: begin
                    if (rx_valid) begin
                        idle_tmr <= '0;
                        if (rx_data == START_CHAR) begin
                            count    <= '0;
                            overflow <= 1'b0;
                        end else if (rx_data != END_CHAR) begin
                            if (count == CNT_W'(CMD_LEN)) begin
                                overflow <= 1'b1;
                            end else begin
                                frame_buf[count] <= rx_data;
                                count            <= count + 1'b1;
                            end
                        end
                    end else begin
                        idle_tmr <= idle_tmr + 1'b1;
                    end
                end
                R_CMP: begin
                    if (hit) begin
                        match_pulse <= 1'b1;
                        match_idx   <= hit_idx;
                    end else begin
                        nomatch_pulse <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Tx next-state logic; tx_start is a Moore output of T_LOAD.
    always_comb begin
        tx_next  = tx_state;
        tx_start = 1'b0;
        load_end = (ptr == PTR_W'(RSP_LEN)) || (tx_data == 8'h00);
        case (tx_state)
            T_IDLE: if (match_pulse) tx_next = T_LOAD;
            T_LOAD: begin
                if (load_end) begin
                    tx_next = T_IDLE;
                end else begin
                    tx_start = 1'b1;
                    tx_next  = T_WAIT;
                end
            end
            T_WAIT:  if (tx_done) tx_next = T_LOAD;
            default: tx_next = T_IDLE;
        endcase
    end

    assign busy       = (tx_state != T_IDLE);
    assign drop_pulse = match_pulse & busy;

    // Tx state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) tx_state <= T_IDLE;
        else      tx_state <= tx_next;
    end

    // Tx datapath: next byte is fetched on entry to T_LOAD and held through T_WAIT.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_idx  <= '0;
            ptr     <= '0;
            tx_data <= 8'h00;
        end else begin
            case (tx_state)
                T_IDLE: begin
                    if (match_pulse) begin
                        tx_idx  <= match_idx;
                        ptr     <= '0;
                        tx_data <= rsp_byte(match_idx, '0);
                    end
                end
                T_WAIT: begin
                    if (tx_done) begin
                        ptr     <= ptr + 1'b1;
                        tx_data <= rsp_byte(tx_idx, ptr + 1'b1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
